// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared constants and types for the ping-pong frame buffer
//               controller (geometry, address width, write-queue entry).
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  // Frame buffer geometry (buffer is half the screen in each direction)
  localparam int H_RES     = 320;
  localparam int V_RES     = 240;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  // Bank address width: 320*240 = 76800 locations
  localparam int FB_ADDR_W = 17;

  // Palette index width carried in each queued write
  localparam int COLOR_W   = 4;

  // One queued pixel write from the drawing engine
  typedef struct packed {
    logic [8:0]         x;
    logic [7:0]         y;
    logic [COLOR_W-1:0] color;
  } fb_wr_t;

  // Bank select strobe: bit b selects bank b
  typedef logic [1:0] bank_sel_t;

  localparam bank_sel_t BANK_NONE = 2'b00;

  // A strobe is well formed when it is zero or one-hot
  function automatic logic strobe_ok(input bank_sel_t s);
    return (s != 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_fifo
// Description : Synchronous FIFO of pending pixel writes. Head is presented
//               combinationally; push is ignored when full, pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4   // power of 2, at least 2
)
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   i_push,
  input  fb_wr_t                 i_data,
  input  logic                   i_pop,
  output fb_wr_t                 o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  fb_wr_t             r_mem [DEPTH];

  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // Full/empty come from the registered count, so a same-cycle pop never
  // makes room for a push and a same-cycle push never feeds a pop.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/fb_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fb_bank_ctrl
// Description : Ping-pong frame buffer controller. Queues drawing-engine
//               writes and retires them in write slots; fetches the pixel
//               under the VGA beam in read slots; tracks bank swaps and
//               flags illegal slot strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_bank_ctrl #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int COLOR_W    = 4,   // must match the queue entry colour width
  parameter int FIFO_DEPTH = 4
)
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic [1:0]         we,
  input  logic [1:0]         re,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [8:0]         wr_x,
  input  logic [7:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  output logic [16:0]        mem0_addr,
  output logic [16:0]        mem1_addr,
  output logic [COLOR_W-1:0] mem0_wdata,
  output logic [COLOR_W-1:0] mem1_wdata,
  output logic               mem0_wen,
  output logic               mem1_wen,
  input  logic [COLOR_W-1:0] mem0_rdata,
  input  logic [COLOR_W-1:0] mem1_rdata,
  output logic [COLOR_W-1:0] pix_color,
  output logic               frame_start,
  output logic               slot_err
);

  import fb_pkg::fb_wr_t;
  import fb_pkg::bank_sel_t;
  import fb_pkg::BANK_NONE;
  import fb_pkg::SCREEN_W;
  import fb_pkg::SCREEN_H;
  import fb_pkg::FB_ADDR_W;
  import fb_pkg::strobe_ok;

  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- signals
  bank_sel_t              r_bank;         // last non-zero write strobe
  logic                   r_fetch_pend;
  logic                   r_fetch_bank;   // 1 = bank 1
  logic                   r_blank_pend;
  logic [COLOR_W-1:0]     r_pix;
  logic                   r_slot_err;

  bank_sel_t              w_we;
  bank_sel_t              w_re;
  logic                   w_illegal;
  logic                   w_wr_slot;
  logic                   w_rd_slot;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head_in;
  logic                   w_wr_go;
  logic                   w_rd_in;
  logic                   w_fetch;
  logic                   w_blank;
  logic [FB_ADDR_W-1:0]   w_wr_addr;
  logic [FB_ADDR_W-1:0]   w_rd_addr;
  fb_wr_t                 w_wr_entry;
  fb_wr_t                 w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [c_CNT_W-1:0]     w_fifo_count;

  // ------------------------------------------------------------ slot decode
  // Strobes are masked during Reset so every mem* output reads as idle.
  assign w_we      = Reset ? BANK_NONE : we;
  assign w_re      = Reset ? BANK_NONE : re;
  assign w_illegal = !strobe_ok(w_we) || !strobe_ok(w_re) ||
                     ((w_we != BANK_NONE) && (w_re != BANK_NONE));
  assign w_wr_slot = (w_we != BANK_NONE) && !w_illegal;
  assign w_rd_slot = (w_re != BANK_NONE) && !w_illegal;

  // ------------------------------------------------------------ write queue
  assign w_wr_entry = '{x: wr_x, y: wr_y, color: wr_color};

  // Ready follows the registered occupancy; the full flag also guards the
  // push so a stray wr_valid can never overwrite a live entry.
  assign wr_ready  = (w_fifo_count != c_CNT_W'(FIFO_DEPTH));
  assign w_push    = wr_valid && wr_ready && !w_fifo_full && !Reset;
  assign w_pop     = w_wr_slot && !w_fifo_empty;

  fb_write_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Out-of-range entries are still popped, just never written
  assign w_head_in = (int'(w_head.x) < H_RES) && (int'(w_head.y) < V_RES);
  assign w_wr_go   = w_pop && w_head_in;
  assign w_wr_addr = FB_ADDR_W'(int'(w_head.y) * H_RES + int'(w_head.x));

  // ------------------------------------------------------------- read slot
  // Screen pixels map 2x2 onto buffer pixels
  assign w_rd_in   = (int'(DrawX) < SCREEN_W) && (int'(DrawY) < SCREEN_H);
  assign w_rd_addr = FB_ADDR_W'(int'(DrawY >> 1) * H_RES + int'(DrawX >> 1));
  assign w_fetch   = w_rd_slot && w_rd_in;
  assign w_blank   = w_rd_slot && !w_rd_in;

  // Bank port drive: only the selected bank sees a non-zero address
  always_comb begin
    mem0_addr  = '0;
    mem1_addr  = '0;
    mem0_wdata = '0;
    mem1_wdata = '0;
    mem0_wen   = 1'b0;
    mem1_wen   = 1'b0;
    if (w_wr_go) begin
      if (w_we[0]) begin
        mem0_addr  = w_wr_addr;
        mem0_wdata = w_head.color;
        mem0_wen   = 1'b1;
      end else begin
        mem1_addr  = w_wr_addr;
        mem1_wdata = w_head.color;
        mem1_wen   = 1'b1;
      end
    end
    if (w_fetch) begin
      if (w_re[0]) mem0_addr = w_rd_addr;
      else         mem1_addr = w_rd_addr;
    end
  end

  // Read pipeline: remember the slot outcome, then capture bank data a cycle later
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fetch_pend <= 1'b0;
      r_fetch_bank <= 1'b0;
      r_blank_pend <= 1'b0;
      r_pix        <= '0;
    end else begin
      r_fetch_pend <= w_fetch;
      r_fetch_bank <= w_re[1];
      r_blank_pend <= w_blank;
      if (r_fetch_pend)      r_pix <= r_fetch_bank ? mem1_rdata : mem0_rdata;
      else if (r_blank_pend) r_pix <= '0;
    end
  end

  assign pix_color = r_pix;

  // Bank tracking: stored bank stays "none" until the first legal write slot
  always_ff @(posedge Clk) begin
    if (Reset)          r_bank <= BANK_NONE;
    else if (w_wr_slot) r_bank <= w_we;
  end

  assign frame_start = w_wr_slot && (r_bank != BANK_NONE) && (w_we != r_bank);

  // Sticky illegal-strobe flag, cleared only by Reset
  always_ff @(posedge Clk) begin
    if (Reset) r_slot_err <= 1'b0;
    else       r_slot_err <= r_slot_err | w_illegal;
  end

  assign slot_err = r_slot_err;

endmodule
`default_nettype wire

// File: doc/fb_bank_ctrl.md
# fb_bank_ctrl

Ping-pong frame buffer controller sitting between the per-pixel slot scheduler (which issues one-hot `we`/`re` bank strobes, alternating write and read slots each clock and swapping banks at the end of each frame) and two single-port frame buffer banks. It queues pixel writes from the drawing engine and retires them only in write slots. In read slots it fetches the pixel under the VGA beam from the display bank and drives the colour to the VGA output stage.

## Interface
Parameters:
- `H_RES`, 320: buffer width in pixels; the screen is 640 wide, so the X scale is 2.
- `V_RES`, 240: buffer height in pixels; the screen is 480 tall, so the Y scale is 2.
- `COLOR_W`, 4: palette index width.
- `FIFO_DEPTH`, 4: write queue depth; must be a power of 2.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `we`  in  2  write-slot strobe; bit b selects bank b; one-hot or zero.
- `re`  in  2  read-slot strobe; bit b selects bank b; one-hot or zero.
- `DrawX`  in  10  beam column, 0..799.
- `DrawY`  in  10  beam row, 0..524.
- `wr_valid`  in  1  drawing engine write request.
- `wr_ready`  out  1  write queue can accept a request.
- `wr_x`  in  9  buffer column.
- `wr_y`  in  8  buffer row.
- `wr_color`  in  COLOR_W  pixel value.
- `mem0_addr`, `mem1_addr`  out  17  bank address.
- `mem0_wdata`, `mem1_wdata`  out  COLOR_W  bank write data.
- `mem0_wen`, `mem1_wen`  out  1  bank write enable.
- `mem0_rdata`, `mem1_rdata`  in  COLOR_W  bank read data; 1-cycle latency.
- `pix_color`  out  COLOR_W  colour to the VGA stage.
- `frame_start`  out  1  one-cycle pulse when the write bank changes.
- `slot_err`  out  1  sticky; set when an illegal strobe is seen.

## Operation
- **Write queue:**
  - FIFO of {x, y, color}, FIFO_DEPTH entries.
  - Push when `wr_valid && wr_ready`.
  - `wr_ready = (count != FIFO_DEPTH)`, computed from the registered count. A pop in the same cycle does not raise it.
- **Write slot (`we` one-hot, bank b):**
  - If the FIFO is non-empty, pop the head.
  - If x<H_RES and y<V_RES: drive `memb_addr = y*H_RES + x`, `memb_wdata = color`, `memb_wen = 1`.
  - Otherwise the entry is dropped with no write.
  - If the FIFO is empty, nothing happens.
- **Read slot (`re` one-hot, bank b):**
  - If DrawX<640 and DrawY<480: drive `memb_addr = (DrawY>>1)*H_RES + (DrawX>>1)` and mark a fetch pending for bank b.
  - Otherwise mark a blank pending.
- **Next cycle after a read slot:**
  - If a fetch is pending, register `memb_rdata` into `pix_color`.
  - If a blank is pending, register 0.
  - `pix_color` holds its value between reads.
- **Bank tracking:**
  - A register stores the last non-zero `we` value.
  - When a new non-zero `we` differs from the stored value, pulse `frame_start` in that same cycle.
  - The first `we` after reset does not pulse.
- **Illegal strobes:** `we==2'b11`, `re==2'b11`, or `we` and `re` both non-zero in one cycle.
  - Set `slot_err`.
  - No memory access, no pop, no fetch.
  - `slot_err` clears only on Reset.
- **Address outputs:**
  - An unused bank's addr/wdata are 0 and its wen is 0.
  - All `mem*` outputs are combinational from the current slot and the FIFO head.
- **Frame-boundary writes:** queued entries are written to whichever bank the current write slot selects. The drawing engine synchronises to `frame_start`.

## Timing
- **Reset values:**
  - FIFO empty, so `wr_ready=1`.
  - `pix_color=0`, `frame_start=0`, `slot_err=0`.
  - All `mem*_wen=0`, addr=0, wdata=0.
  - Stored bank = none.
- **Reset mid-operation:** queued writes are discarded and the pending fetch is cancelled.
- **Write latency:** a request accepted in cycle N is written in the first write slot at N+1 or later, behind older entries.
- **Read latency:** a read slot in cycle N gives `pix_color` valid from N+2.
- **Throughput:** at most one pop per write slot, i.e. one every 2 cycles. Sustained `wr_valid` therefore sees `wr_ready` drop once the FIFO fills.
- **Full FIFO with simultaneous push attempt and pop:** the push is refused and the count goes to FIFO_DEPTH-1.
- **Empty FIFO with simultaneous push and write slot:** no write in that cycle; the entry is written in the next write slot.

## Structure
- **Package `fb_pkg`:**
  - `H_RES`, `V_RES`, `SCREEN_W=640`, `SCREEN_H=480`.
  - `FB_ADDR_W=17`.
  - `typedef struct packed {logic [8:0] x; logic [7:0] y; logic [COLOR_W-1:0] color;} fb_wr_t`.
  - `typedef logic [1:0] bank_sel_t`.
- **Sub-module `fb_write_fifo`:** synchronous FIFO of `fb_wr_t` with push/pop/full/empty/count. The rest (slot decode, address multiply by a constant, read pipeline, bank tracking) stays in `fb_bank_ctrl`.

## Test plan
1. **Reset:**
   - Stimulus: assert Reset 2 cycles with random inputs.
   - Required: `pix_color=0`, `wr_ready=1`, all `wen=0`, `slot_err=0`.
2. **Write then read back:**
   - Stimulus: push (x=5, y=3, color=9), then alternate `we=01` / `re=10` slots.
   - Required: `mem0_wen=1` with addr 965 and data 9.
   - Stimulus: later `re=01` at DrawX=10, DrawY=6.
   - Required: addr 965, and `pix_color=9` two cycles after the read slot.
3. **Backpressure:**
   - Stimulus: hold `wr_valid` with no write slots.
   - Required: `wr_ready` drops after 4 accepts.
   - Stimulus: one `we=01` slot.
   - Required: `wr_ready=1` the next cycle; entries retire in FIFO order.
4. **Out-of-range and blanking:**
   - Stimulus: push x=320.
   - Required: popped with no `wen`.
   - Stimulus: read slot at DrawX=700.
   - Required: no fetch; `pix_color=0` at N+2.
5. **Bank swap:**
   - Stimulus: `we` sequence 01,01,10.
   - Required: `frame_start` pulses only on the cycle with 10.
   - Required: the next write goes to bank 1 with `mem0_wen=0`.
6. **Illegal strobe:**
   - Stimulus: `we=11` with a non-empty FIFO.
   - Required: `slot_err=1` and stays set; FIFO count unchanged; no `wen`.
